// File: rtl/mycpu_pkg.sv
// Shared widths, select-word field offsets and types for the mycpu datapath.
// Field offsets describe the packed select word: {W, RA, RB}.
package mycpu_pkg;
  localparam int DATA_WIDTH    = 16;
  localparam int REG_SEL_WIDTH = 4;
  localparam int NUM_REGS      = 16;

  localparam int W_LSB  = 8;
  localparam int RA_LSB = 4;
  localparam int RB_LSB = 0;

  localparam int CLK_PERIOD = 10;

  typedef logic [15:0] word_t;
  typedef logic [3:0]  reg_sel_t;
endpackage

// File: rtl/rb_read_mux.sv
// 2**AW:1 read multiplexer, DW wide; purely combinational, no backpressure.
module rb_read_mux #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic [2**AW-1:0][DW-1:0] i_regs,
  input  logic [AW-1:0]            i_sel,
  output logic [DW-1:0]            o_dat
);
  assign o_dat = i_regs[i_sel];
endmodule

// File: rtl/register_bank.sv
// 2**AW x DW register file: one synchronous write port, two combinational read ports.
// Write lands on the next rising edge; reads have zero latency with no write bypass.
module register_bank
  import mycpu_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = REG_SEL_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   d_in,
  input  logic            rw_in,
  input  logic [3*AW-1:0] rs_in,
  output logic [DW-1:0]   a_out,
  output logic [DW-1:0]   b_out
);
  localparam int N = 2**AW;

  logic [N-1:0][DW-1:0] r_regs;
  logic [AW-1:0]        w_wsel;
  logic [AW-1:0]        w_rasel;
  logic [AW-1:0]        w_rbsel;

  assign w_wsel  = rs_in[2*AW +: AW];
  assign w_rasel = rs_in[AW   +: AW];
  assign w_rbsel = rs_in[0    +: AW];

  // rst_n is active-high here: a 1 clears the bank and overrides any write.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_regs <= '0;
    end else if (rw_in) begin
      r_regs[w_wsel] <= d_in;
    end
  end

  rb_read_mux #(.DW(DW), .AW(AW)) u_mux_a (
    .i_regs (r_regs),
    .i_sel  (w_rasel),
    .o_dat  (a_out)
  );

  rb_read_mux #(.DW(DW), .AW(AW)) u_mux_b (
    .i_regs (r_regs),
    .i_sel  (w_rbsel),
    .o_dat  (b_out)
  );
endmodule

// File: tb/tb_register_bank.sv
// Randomised and directed checks of register_bank against an array model of the register file.
module tb_register_bank;
  import mycpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] d_in;
  logic        rw_in;
  logic [11:0] rs_in;
  logic [15:0] a_out;
  logic [15:0] b_out;

  int total;
  int bad;
  word_t model [NUM_REGS];

  register_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (d_in),
    .rw_in (rw_in),
    .rs_in (rs_in),
    .a_out (a_out),
    .b_out (b_out)
  );

  initial clk = 1'b0;
  always #(CLK_PERIOD/2) clk = ~clk;

  // One rising edge: the model applies the architectural rule, then we park at negedge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) model[k] = 16'h0000;
    end else if (rw_in) begin
      model[rs_in[W_LSB +: 4]] = d_in;
    end
    @(negedge clk);
  endtask

  task automatic set_sel(input reg_sel_t w, input reg_sel_t ra, input reg_sel_t rb);
    rs_in = {w, ra, rb};
  endtask

  task automatic write_reg(input reg_sel_t w, input word_t d);
    rw_in = 1'b1;
    d_in  = d;
    rs_in[W_LSB +: 4] = w;
    tick();
    rw_in = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NUM_REGS; i++) write_reg(reg_sel_t'(i), word_t'($urandom));
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      set_sel(4'd0, reg_sel_t'(i), reg_sel_t'(15 - i));
      #1;
      total++;
      if (a_out !== 16'h0000) begin
        bad++;
        $display("FAIL reset_a sel=%0d got=%h exp=0000", i, a_out);
      end
      total++;
      if (b_out !== 16'h0000) begin
        bad++;
        $display("FAIL reset_b sel=%0d got=%h exp=0000", 15 - i, b_out);
      end
    end
  endtask

  task automatic test_write_readback();
    for (int i = 0; i < NUM_REGS; i++) write_reg(reg_sel_t'(i), 16'hA500 + 16'(i));
    for (int i = 0; i < NUM_REGS; i++) begin
      set_sel(4'd0, reg_sel_t'(i), reg_sel_t'(15 - i));
      #1;
      total++;
      if (a_out !== 16'hA500 + 16'(i)) begin
        bad++;
        $display("FAIL readback_a ra=%0d got=%h exp=%h", i, a_out, 16'hA500 + 16'(i));
      end
      total++;
      if (b_out !== 16'hA50F - 16'(i)) begin
        bad++;
        $display("FAIL readback_b rb=%0d got=%h exp=%h", 15 - i, b_out, 16'hA50F - 16'(i));
      end
    end
  endtask

  task automatic test_wen_low();
    rw_in = 1'b0;
    d_in  = 16'hFFFF;
    set_sel(4'd3, 4'd3, 4'd3);
    tick();
    total++;
    if (a_out !== 16'hA503) begin
      bad++;
      $display("FAIL wen_low got=%h exp=a503", a_out);
    end
  endtask

  task automatic test_same_reg();
    set_sel(4'd5, 4'd5, 4'd5);
    d_in  = 16'h1234;
    rw_in = 1'b1;
    #1;
    total++;
    if (a_out !== 16'hA505 || b_out !== 16'hA505) begin
      bad++;
      $display("FAIL same_reg_before a=%h b=%h exp=a505", a_out, b_out);
    end
    tick();
    rw_in = 1'b0;
    #1;
    total++;
    if (a_out !== 16'h1234 || b_out !== 16'h1234) begin
      bad++;
      $display("FAIL same_reg_after a=%h b=%h exp=1234", a_out, b_out);
    end
  endtask

  task automatic test_reset_priority();
    rst_n = 1'b1;
    rw_in = 1'b1;
    d_in  = 16'hBEEF;
    set_sel(4'd7, 4'd7, 4'd0);
    tick();
    rst_n = 1'b0;
    rw_in = 1'b0;
    #1;
    total++;
    if (a_out !== 16'h0000) begin
      bad++;
      $display("FAIL reset_priority got=%h exp=0000", a_out);
    end
    // The first edge after reset deasserts must accept a write again.
    write_reg(4'd7, 16'h5A5A);
    set_sel(4'd0, 4'd7, 4'd7);
    #1;
    total++;
    if (b_out !== 16'h5A5A) begin
      bad++;
      $display("FAIL write_after_reset got=%h exp=5a5a", b_out);
    end
  endtask

  task automatic test_boundaries();
    for (int i = 0; i < NUM_REGS; i++) write_reg(reg_sel_t'(i), word_t'($urandom));
    write_reg(4'd0, 16'hFFFF);
    write_reg(4'd15, 16'h8001);
    set_sel(4'd0, 4'd0, 4'd15);
    #1;
    total++;
    if (a_out !== 16'hFFFF) begin
      bad++;
      $display("FAIL boundary_reg0 got=%h exp=ffff", a_out);
    end
    total++;
    if (b_out !== 16'h8001) begin
      bad++;
      $display("FAIL boundary_reg15 got=%h exp=8001", b_out);
    end
    for (int i = 1; i < NUM_REGS - 1; i++) begin
      set_sel(4'd0, reg_sel_t'(i), reg_sel_t'(i));
      #1;
      total++;
      if (a_out !== model[i]) begin
        bad++;
        $display("FAIL boundary_undisturbed r=%0d got=%h exp=%h", i, a_out, model[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rst_n = ($urandom_range(0, 15) == 0);
      rw_in = rst_n ? 1'b0 : 1'($urandom);
      d_in  = word_t'($urandom);
      rs_in = 12'($urandom);
      #1;
      total++;
      if (a_out !== model[rs_in[RA_LSB +: 4]] || b_out !== model[rs_in[RB_LSB +: 4]]) begin
        bad++;
        $display("FAIL random n=%0d a=%h exp_a=%h b=%h exp_b=%h", n, a_out,
                 model[rs_in[RA_LSB +: 4]], b_out, model[rs_in[RB_LSB +: 4]]);
      end
      tick();
    end
    rst_n = 1'b0;
    rw_in = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    rw_in = 1'b0;
    d_in  = 16'h0000;
    rs_in = 12'h000;
    for (int k = 0; k < NUM_REGS; k++) model[k] = 16'h0000;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (a_out !== 16'h0000 || b_out !== 16'h0000) begin
      bad++;
      $display("FAIL initial_reset a=%h b=%h exp=0000", a_out, b_out);
    end
    @(negedge clk);

    test_reset();
    test_write_readback();
    test_wen_low();
    test_same_reg();
    test_reset_priority();
    test_boundaries();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
